// File: rtl/iiitb_ptvm_multi.sv
`default_nettype none
// ============================================================================
// Module  : iiitb_ptvm_multi
// Brief   : Two-fare ticket vending controller with coin accumulation,
//           change return, cancel and idle-timeout refund.
// Revision: 1.0 - initial release
// ============================================================================
module iiitb_ptvm_multi #(
    parameter int CW      = 4,
    parameter int PRICE0  = 3,
    parameter int PRICE1  = 5,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_valid,
    input  logic [1:0]    coin,
    input  logic          sel,
    input  logic          cancel,
    output logic          vend,
    output logic          refund,
    output logic          change_valid,
    output logic [CW-1:0] change,
    output logic [CW-1:0] credit,
    output logic          reject,
    output logic          busy
);

    // Sum width covers the largest credit plus the 5-unit coin without wrap.
    localparam int            SW        = (CW >= 3) ? (CW + 1) : 4;
    localparam int            MAXC      = (1 << CW) - 1;
    localparam logic [SW-1:0] C_MAX     = SW'(MAXC);
    localparam logic [SW-1:0] C_PRICE0  = SW'(PRICE0);
    localparam logic [SW-1:0] C_PRICE1  = SW'(PRICE1);
    localparam logic [7:0]    C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [7:0]    timer_q, timer_d;
    logic          sel_q, sel_d;
    logic          reject_q, reject_d;

    logic [2:0]    w_coin_val;
    logic          w_coin_ok;
    logic [SW-1:0] w_sum;
    logic          w_fits;
    logic [SW-1:0] w_price_in;
    logic [SW-1:0] w_price_lat;
    logic [7:0]    w_timer_inc;

    always_comb begin
        w_coin_val = 3'd0;
        case (coin)
            2'b01:   w_coin_val = 3'd1;
            2'b10:   w_coin_val = 3'd2;
            2'b11:   w_coin_val = 3'd5;
            default: w_coin_val = 3'd0;
        endcase
    end

    assign w_coin_ok   = coin_valid && (coin != 2'b00);
    assign w_sum       = SW'(credit_q) + SW'(w_coin_val);
    assign w_fits      = (w_sum <= C_MAX);
    assign w_price_in  = sel   ? C_PRICE1 : C_PRICE0;
    assign w_price_lat = sel_q ? C_PRICE1 : C_PRICE0;
    assign w_timer_inc = timer_q + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            timer_q  <= '0;
            sel_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            sel_q    <= sel_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        sel_d    = sel_q;
        reject_d = coin_valid && (coin == 2'b00);

        case (state_q)
            ST_IDLE: begin
                if (w_coin_ok) begin
                    if (w_fits) begin
                        credit_d = w_sum[CW-1:0];
                        sel_d    = sel;
                        timer_d  = '0;
                        state_d  = (w_sum >= w_price_in) ? ST_VEND : ST_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    // Cancel has priority; any coin arriving with it goes back.
                    state_d  = ST_REFUND;
                    reject_d = coin_valid;
                end else if (w_coin_ok && w_fits) begin
                    credit_d = w_sum[CW-1:0];
                    timer_d  = '0;
                    if (w_sum >= w_price_lat) begin
                        state_d = ST_VEND;
                    end
                end else begin
                    if (w_coin_ok) begin
                        reject_d = 1'b1;
                    end
                    timer_d = w_timer_inc;
                    if (w_timer_inc >= C_TIMEOUT) begin
                        state_d = ST_REFUND;
                    end
                end
            end
            ST_VEND, ST_REFUND: begin
                state_d  = ST_IDLE;
                credit_d = '0;
                timer_d  = '0;
                reject_d = coin_valid;
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
                timer_d  = '0;
            end
        endcase
    end

    // All outputs decode from registered state so they are glitch-free.
    assign vend         = (state_q == ST_VEND);
    assign refund       = (state_q == ST_REFUND);
    assign change_valid = vend || refund;
    assign change       = vend   ? (credit_q - w_price_lat[CW-1:0]) :
                          refund ? credit_q : '0;
    assign credit       = credit_q;
    assign reject       = reject_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iiitb_ptvm_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_iiitb_ptvm_multi
// Brief   : Scoreboard bench for iiitb_ptvm_multi (two fare configurations).
// Revision: 1.0 - initial release
// ============================================================================
module tb_iiitb_ptvm_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      cv, sel, cancel;
    logic [1:0][1:0] coin;
    logic [1:0]      vend, refund, cval, reject, busy;
    logic [1:0][3:0] change, credit;

    iiitb_ptvm_multi #(.CW(4), .PRICE0(3), .PRICE1(5), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst), .coin_valid(cv[0]), .coin(coin[0]), .sel(sel[0]),
        .cancel(cancel[0]), .vend(vend[0]), .refund(refund[0]),
        .change_valid(cval[0]), .change(change[0]), .credit(credit[0]),
        .reject(reject[0]), .busy(busy[0]));

    iiitb_ptvm_multi #(.CW(4), .PRICE0(3), .PRICE1(15), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .coin_valid(cv[1]), .coin(coin[1]), .sel(sel[1]),
        .cancel(cancel[1]), .vend(vend[1]), .refund(refund[1]),
        .change_valid(cval[1]), .change(change[1]), .credit(credit[1]),
        .reject(reject[1]), .busy(busy[1]));

    typedef struct {
        int         inst;
        logic       is_vend;
        logic [3:0] chg;
    } xfer_t;

    xfer_t xq[$];
    int    rq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic exp_x(int i, logic v, int c);
        xfer_t e;
        e.inst    = i;
        e.is_vend = v;
        e.chg     = 4'(c);
        xq.push_back(e);
    endtask

    task automatic exp_r(int i);
        rq.push_back(i);
    endtask

    task automatic drive(int i, logic v, logic [1:0] c, logic s, logic cn);
        cv[i]     = v;
        coin[i]   = c;
        sel[i]    = s;
        cancel[i] = cn;
        @(posedge clk);
        #1;
        cv[i]     = 1'b0;
        coin[i]   = 2'b00;
        cancel[i] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents change or reject.
    xfer_t m_e;
    int    m_r;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("vend_refund_exclusive", int'(vend[i] & refund[i]), 0);
            if (!cval[i]) chk("change_zero_when_invalid", int'(change[i]), 0);
            if (cval[i]) begin
                if (xq.size() == 0) begin
                    chk("unexpected_change_valid", int'(cval[i]), 0);
                end else begin
                    m_e = xq.pop_front();
                    chk("xfer_instance", i, m_e.inst);
                    chk("xfer_vend", int'(vend[i]), int'(m_e.is_vend));
                    chk("xfer_refund", int'(refund[i]), int'(!m_e.is_vend));
                    chk("xfer_change", int'(change[i]), int'(m_e.chg));
                end
            end
            if (reject[i]) begin
                if (rq.size() == 0) begin
                    chk("unexpected_reject", int'(reject[i]), 0);
                end else begin
                    m_r = rq.pop_front();
                    chk("reject_instance", i, m_r);
                end
            end
        end
    end

    initial begin
        rst    = 1'b0;
        cv     = '0;
        coin   = '0;
        sel    = '0;
        cancel = '0;
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset_credit", int'(credit[i]), 0);
            chk("reset_busy", int'(busy[i]), 0);
            chk("reset_change_valid", int'(cval[i]), 0);
            chk("reset_change", int'(change[i]), 0);
            chk("reset_vend", int'(vend[i]), 0);
            chk("reset_refund", int'(refund[i]), 0);
            chk("reset_reject", int'(reject[i]), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fare 3: coins 1 then 2, exact fare
        drive(0, 1'b1, 2'b01, 1'b0, 1'b0);
        chk("t1_credit1", int'(credit[0]), 1);
        chk("t1_busy", int'(busy[0]), 1);
        exp_x(0, 1'b1, 0);
        drive(0, 1'b1, 2'b10, 1'b0, 1'b0);
        chk("t1_credit3", int'(credit[0]), 3);
        chk("t1_vend", int'(vend[0]), 1);
        idle(1);
        chk("t1_idle_busy", int'(busy[0]), 0);
        chk("t1_idle_credit", int'(credit[0]), 0);
        chk("t1_vend_one_cycle", int'(vend[0]), 0);

        // Fare 5: coins 2 then 5, change 2
        drive(0, 1'b1, 2'b10, 1'b1, 1'b0);
        chk("t2_credit2", int'(credit[0]), 2);
        exp_x(0, 1'b1, 2);
        drive(0, 1'b1, 2'b11, 1'b1, 1'b0);
        chk("t2_credit7", int'(credit[0]), 7);
        idle(1);
        chk("t2_idle_busy", int'(busy[0]), 0);

        // Cancel with simultaneous coin: coin rejected, credit 2 refunded
        drive(0, 1'b1, 2'b10, 1'b1, 1'b0);
        chk("t3_credit2", int'(credit[0]), 2);
        exp_r(0);
        exp_x(0, 1'b0, 2);
        drive(0, 1'b1, 2'b01, 1'b1, 1'b1);
        chk("t3_refund", int'(refund[0]), 1);
        chk("t3_vend_low", int'(vend[0]), 0);
        chk("t3_credit_kept", int'(credit[0]), 2);
        idle(1);
        chk("t3_idle_busy", int'(busy[0]), 0);

        // Idle timeout after 8 coinless cycles
        drive(0, 1'b1, 2'b01, 1'b0, 1'b0);
        chk("t4_credit1", int'(credit[0]), 1);
        idle(7);
        chk("t4_no_early_refund", int'(refund[0]), 0);
        chk("t4_still_busy", int'(busy[0]), 1);
        exp_x(0, 1'b0, 1);
        idle(1);
        chk("t4_refund", int'(refund[0]), 1);
        idle(1);
        chk("t4_idle_busy", int'(busy[0]), 0);

        // Invalid coin code and cancel while IDLE
        exp_r(0);
        drive(0, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("t5_invalid_stays_idle", int'(busy[0]), 0);
        chk("t5_invalid_credit", int'(credit[0]), 0);
        drive(0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("t5_cancel_idle_ignored", int'(busy[0]), 0);

        // Direct vend from IDLE, coin during VEND rejected
        exp_x(0, 1'b1, 2);
        drive(0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("t6_direct_vend", int'(vend[0]), 1);
        chk("t6_credit5", int'(credit[0]), 5);
        exp_r(0);
        drive(0, 1'b1, 2'b01, 1'b0, 1'b0);
        chk("t6_back_idle", int'(busy[0]), 0);
        chk("t6_credit_cleared", int'(credit[0]), 0);
        idle(1);

        // Fare 15: overflow rejection then exact fare
        drive(1, 1'b1, 2'b11, 1'b1, 1'b0);
        chk("t7_credit5", int'(credit[1]), 5);
        drive(1, 1'b1, 2'b11, 1'b1, 1'b0);
        chk("t7_credit10", int'(credit[1]), 10);
        drive(1, 1'b1, 2'b10, 1'b1, 1'b0);
        chk("t7_credit12", int'(credit[1]), 12);
        exp_r(1);
        drive(1, 1'b1, 2'b11, 1'b1, 1'b0);
        chk("t7_overflow_credit", int'(credit[1]), 12);
        chk("t7_overflow_busy", int'(busy[1]), 1);
        drive(1, 1'b1, 2'b10, 1'b1, 1'b0);
        chk("t7_credit14", int'(credit[1]), 14);
        exp_x(1, 1'b1, 0);
        drive(1, 1'b1, 2'b01, 1'b1, 1'b0);
        chk("t7_credit15", int'(credit[1]), 15);
        chk("t7_vend", int'(vend[1]), 1);
        idle(1);
        chk("t7_idle_busy", int'(busy[1]), 0);

        // Asynchronous reset mid-COLLECT
        drive(0, 1'b1, 2'b10, 1'b1, 1'b0);
        chk("t8_credit2", int'(credit[0]), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t8_async_credit", int'(credit[0]), 0);
        chk("t8_async_busy", int'(busy[0]), 0);
        chk("t8_async_vend", int'(vend[0]), 0);
        chk("t8_async_refund", int'(refund[0]), 0);
        chk("t8_async_change_valid", int'(cval[0]), 0);
        chk("t8_async_reject", int'(reject[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        chk("t8_post_reset_idle", int'(busy[0]), 0);
        chk("t8_post_reset_credit", int'(credit[0]), 0);
        exp_x(0, 1'b1, 2);
        drive(0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("t8_post_reset_vend", int'(vend[0]), 1);
        idle(2);

        chk("xfer_queue_drained", xq.size(), 0);
        chk("reject_queue_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
